exc_commit_ctrl: RTL and testbench

// - Exception/interrupt sequencer at the MEM/commit stage of the 5-stage CPU.
// - Arbitrates the committing instruction's exception sources, the pending CP0 interrupt and ERET.
// - Drives the CP0 register file's exception/return update strobes and fields.
// - Flushes the pipeline, then hands a redirect PC to the fetch stage with a valid/ack handshake.

---
 rtl/exc_commit_ctrl_if.sv | 43 ++++
 rtl/exc_commit_ctrl.sv | 138 +++++++++++++
 tb/tb_exc_commit_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_ctrl_if.sv
// Commit-stage <-> exception sequencer bundle: committing instruction info,
// CP0 status/EPC inputs, CP0 update strobes/fields, flush and fetch redirect.
// master = pipeline/CP0/fetch side, slave = exc_commit_ctrl.
interface exc_commit_ctrl_if;
  // commit stage
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [6:0]  mem_exc;
  logic [31:0] mem_addr;
  logic        mem_eret;
  // CP0 state
  logic        cp0_interupt;
  logic        cp0_exl;
  logic [31:0] cp0_return_addr;
  // CP0 update
  logic        cp0_exception;
  logic        cp0_return;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_epc;
  logic        cp0_bd;
  logic [31:0] cp0_badvaddr;
  // pipeline control / fetch redirect
  logic        flush;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ack;
  logic        busy;

  modport master (
    output mem_valid, mem_pc, mem_bd, mem_exc, mem_addr, mem_eret,
    output cp0_interupt, cp0_exl, cp0_return_addr, redir_ack,
    input  cp0_exception, cp0_return, cp0_exccode, cp0_epc, cp0_bd, cp0_badvaddr,
    input  flush, redir_valid, redir_pc, busy
  );

  modport slave (
    input  mem_valid, mem_pc, mem_bd, mem_exc, mem_addr, mem_eret,
    input  cp0_interupt, cp0_exl, cp0_return_addr, redir_ack,
    output cp0_exception, cp0_return, cp0_exccode, cp0_epc, cp0_bd, cp0_badvaddr,
    output flush, redir_valid, redir_pc, busy
  );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt/ERET sequencer at the commit stage: picks the winning event,
// strobes CP0, flushes IF..MEM for FLUSH_CYCLES, then offers a redirect PC to fetch.
// Ports: clk, rstn (sync, active-low), bus (exc_commit_ctrl_if.slave), and
// exc_count[CNT_W-1:0] only when EXC_STATS_EN is defined (saturating exception count).
// Latency: event cycle -> redir_valid is FLUSH_CYCLES+1 cycles; redirect held until redir_ack.
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
`ifdef EXC_STATS_EN
  ,
  parameter int          CNT_W        = 16
`endif
) (
  input  logic              clk,
  input  logic              rstn,
  exc_commit_ctrl_if.slave  bus
`ifdef EXC_STATS_EN
  ,
  output logic [CNT_W-1:0]  exc_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  // Counter counts FLUSH_CYCLES-1 down to 0, so FLUSH lasts exactly FLUSH_CYCLES cycles.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  flush_cnt;
  logic [31:0] redir_pc_q;

  logic        in_idle;
  logic        intr_take;
  logic        exc_any;
  logic        take_exc;
  logic        take_ret;
  logic [4:0]  code;
  logic [31:0] badv;
  logic [31:0] epc;

  // Event decode. Gating with rstn keeps strobes quiet while reset is held.
  always_comb begin
    in_idle   = (state == ST_IDLE) && rstn;
    intr_take = bus.cp0_interupt & ~bus.cp0_exl & bus.mem_valid;
    exc_any   = bus.mem_valid & (|bus.mem_exc);
    take_exc  = in_idle & (intr_take | exc_any);
    // An exception on the ERET itself wins, so ERET only returns when nothing else fires.
    take_ret  = in_idle & bus.mem_valid & bus.mem_eret & ~(intr_take | exc_any);

    code = 5'd0;
    badv = 32'd0;
    if (intr_take) begin
      code = 5'd0;
    end else if (bus.mem_exc[0]) begin
      code = 5'd4;
      badv = bus.mem_pc;
    end else if (bus.mem_exc[1]) begin
      code = 5'd10;
    end else if (bus.mem_exc[2]) begin
      code = 5'd8;
    end else if (bus.mem_exc[3]) begin
      code = 5'd9;
    end else if (bus.mem_exc[4]) begin
      code = 5'd12;
    end else if (bus.mem_exc[5]) begin
      code = 5'd4;
      badv = bus.mem_addr;
    end else if (bus.mem_exc[6]) begin
      code = 5'd5;
      badv = bus.mem_addr;
    end

    // Delay-slot instructions restart at the branch.
    epc = bus.mem_bd ? (bus.mem_pc - 32'd4) : bus.mem_pc;
  end

  // CP0 fields are forced to zero outside an exception strobe so they never leak stale data.
  assign bus.cp0_exception = take_exc;
  assign bus.cp0_return    = take_ret;
  assign bus.cp0_exccode   = take_exc ? code : 5'd0;
  assign bus.cp0_epc       = take_exc ? epc : 32'd0;
  assign bus.cp0_bd        = take_exc & bus.mem_bd;
  assign bus.cp0_badvaddr  = take_exc ? badv : 32'd0;

  assign bus.flush         = take_exc | take_ret | (state == ST_FLUSH);
  assign bus.redir_valid   = (state == ST_REDIR);
  assign bus.redir_pc      = redir_pc_q;
  assign bus.busy          = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      flush_cnt  <= 4'd0;
      redir_pc_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_exc) begin
            redir_pc_q <= EXC_VECTOR;
            flush_cnt  <= FLUSH_LOAD;
            state      <= ST_FLUSH;
          end else if (take_ret) begin
            redir_pc_q <= bus.cp0_return_addr;
            flush_cnt  <= FLUSH_LOAD;
            state      <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state <= ST_REDIR;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        ST_REDIR: begin
          if (bus.redir_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef EXC_STATS_EN
  // Counts exception/interrupt strobes only; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exc_count <= '0;
    end else if (take_exc && !(&exc_count)) begin
      exc_count <= exc_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
module tb_exc_commit_ctrl;

  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;

  logic clk;
  logic rstn;
  exc_commit_ctrl_if bus();
`ifdef EXC_STATS_EN
  logic [15:0] exc_count;
`endif

  exc_commit_ctrl #(
    .EXC_VECTOR  (EXC_VECTOR),
    .FLUSH_CYCLES(FLUSH_CYCLES)
`ifdef EXC_STATS_EN
    ,
    .CNT_W       (16)
`endif
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
`ifdef EXC_STATS_EN
    ,
    .exc_count(exc_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [6:0]  exc;
    logic [31:0] addr;
    logic        eret;
    logic        intr;
    logic        exl;
    logic [31:0] ra;
    logic        e_exc;
    logic        e_ret;
    logic [4:0]  e_code;
    logic [31:0] e_epc;
    logic        e_bd;
    logic [31:0] e_badv;
    logic [31:0] e_redir;
  } vec_t;

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic bd,
                              input logic [6:0] exc, input logic [31:0] addr, input logic eret,
                              input logic intr, input logic exl, input logic [31:0] ra,
                              input logic e_exc, input logic e_ret, input logic [4:0] e_code,
                              input logic [31:0] e_epc, input logic e_bd,
                              input logic [31:0] e_badv, input logic [31:0] e_redir);
    vec_t v;
    v.valid = valid; v.pc = pc; v.bd = bd; v.exc = exc; v.addr = addr; v.eret = eret;
    v.intr = intr; v.exl = exl; v.ra = ra;
    v.e_exc = e_exc; v.e_ret = e_ret; v.e_code = e_code; v.e_epc = e_epc; v.e_bd = e_bd;
    v.e_badv = e_badv; v.e_redir = e_redir;
    return v;
  endfunction

  // Reference: flags are listed in priority order, so the lowest set bit wins after interrupt.
  function automatic vec_t model(input vec_t v);
    int   code_of [7] = '{4, 10, 8, 9, 12, 4, 5};
    int   win;
    logic intr_t;
    vec_t r;
    r = v;
    r.e_exc = 0; r.e_ret = 0; r.e_code = 0; r.e_epc = 0; r.e_bd = 0; r.e_badv = 0; r.e_redir = 0;
    if (!v.valid) return r;
    intr_t = v.intr && !v.exl;
    win = -1;
    for (int i = 6; i >= 0; i--) if (v.exc[i]) win = i;
    if (intr_t || win >= 0) begin
      r.e_exc   = 1;
      r.e_code  = intr_t ? 5'd0 : 5'(code_of[win]);
      r.e_epc   = v.bd ? v.pc - 32'd4 : v.pc;
      r.e_bd    = v.bd;
      r.e_badv  = intr_t ? 32'd0 : (win == 0) ? v.pc : (win >= 5) ? v.addr : 32'd0;
      r.e_redir = EXC_VECTOR;
    end else if (v.eret) begin
      r.e_ret   = 1;
      r.e_redir = v.ra;
    end
    return r;
  endfunction

  task automatic clear_inputs();
    bus.mem_valid = 0; bus.mem_pc = 0; bus.mem_bd = 0; bus.mem_exc = 0; bus.mem_addr = 0;
    bus.mem_eret = 0; bus.cp0_interupt = 0; bus.cp0_exl = 0; bus.cp0_return_addr = 0;
  endtask

  task automatic drive(input vec_t v);
    bus.mem_valid = v.valid; bus.mem_pc = v.pc; bus.mem_bd = v.bd; bus.mem_exc = v.exc;
    bus.mem_addr = v.addr; bus.mem_eret = v.eret; bus.cp0_interupt = v.intr;
    bus.cp0_exl = v.exl; bus.cp0_return_addr = v.ra;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run(input vec_t v, input int ack_dly);
    int fl;
    int t;
    logic [31:0] held;
    drive(v);
    @(negedge clk);
    chk("cp0_exception", bus.cp0_exception, v.e_exc);
    chk("cp0_return", bus.cp0_return, v.e_ret);
    chk("flush_event", bus.flush, v.e_exc | v.e_ret);
    if (v.e_exc) begin
      chk("exccode", bus.cp0_exccode, v.e_code);
      chk("epc", bus.cp0_epc, v.e_epc);
      chk("bd", bus.cp0_bd, v.e_bd);
      chk("badvaddr", bus.cp0_badvaddr, v.e_badv);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    if (v.e_exc || v.e_ret) begin
      fl = 0;
      t  = 0;
      while (!bus.redir_valid && t < 40) begin
        if (bus.flush) fl++;
        chk("no_strobe_flush", bus.cp0_exception | bus.cp0_return, 0);
        t++;
        @(negedge clk);
      end
      chk("flush_cycles", fl, FLUSH_CYCLES);
      chk("redir_valid", bus.redir_valid, 1);
      chk("redir_flush_low", bus.flush, 0);
      chk("redir_pc", bus.redir_pc, v.e_redir);
      held = bus.redir_pc;
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        chk("redir_hold_valid", bus.redir_valid, 1);
        chk("redir_hold_pc", bus.redir_pc, held);
      end
      bus.redir_ack = 1;
      @(posedge clk); #1;
      bus.redir_ack = 0;
      @(negedge clk);
      chk("idle_after_ack", bus.busy, 0);
      chk("redir_valid_drop", bus.redir_valid, 0);
    end else begin
      chk("no_event_busy", bus.busy, 0);
    end
    @(posedge clk); #1;
  endtask

  vec_t tbl [13];
  vec_t rv;
  int   t;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 0;
    bus.redir_ack = 0;
    clear_inputs();

    //            valid pc            bd exc         addr          eret intr exl ra
    //            e_exc e_ret code epc           bd badv          redir
    tbl[0]  = mk(1, 32'h00400010, 0, 7'b0000100, 32'h0, 0, 0, 0, 32'h0,
                 1, 0, 5'd8, 32'h00400010, 0, 32'h0, EXC_VECTOR);
    tbl[1]  = mk(1, 32'h00400024, 1, 7'b0010000, 32'h0, 0, 0, 0, 32'h0,
                 1, 0, 5'd12, 32'h00400020, 1, 32'h0, EXC_VECTOR);
    tbl[2]  = mk(1, 32'h00400030, 0, 7'b1000000, 32'h10000003, 0, 0, 0, 32'h0,
                 1, 0, 5'd5, 32'h00400030, 0, 32'h10000003, EXC_VECTOR);
    tbl[3]  = mk(1, 32'h00400040, 0, 7'b0010010, 32'h0, 0, 0, 0, 32'h0,
                 1, 0, 5'd10, 32'h00400040, 0, 32'h0, EXC_VECTOR);
    tbl[4]  = mk(1, 32'h00400050, 0, 7'b0000100, 32'h0, 0, 1, 0, 32'h0,
                 1, 0, 5'd0, 32'h00400050, 0, 32'h0, EXC_VECTOR);
    tbl[5]  = mk(1, 32'h00400060, 0, 7'b0000000, 32'h0, 0, 1, 1, 32'h0,
                 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    tbl[6]  = mk(1, 32'h00400070, 0, 7'b0000000, 32'h0, 1, 0, 0, 32'h00400100,
                 0, 1, 5'd0, 32'h0, 0, 32'h0, 32'h00400100);
    tbl[7]  = mk(1, 32'h00400003, 0, 7'b0000001, 32'h0, 0, 0, 0, 32'h0,
                 1, 0, 5'd4, 32'h00400003, 0, 32'h00400003, EXC_VECTOR);
    tbl[8]  = mk(1, 32'h00400080, 0, 7'b0101000, 32'h00000101, 0, 0, 0, 32'h0,
                 1, 0, 5'd9, 32'h00400080, 0, 32'h0, EXC_VECTOR);
    tbl[9]  = mk(0, 32'h00400090, 0, 7'b0000100, 32'h0, 1, 1, 0, 32'h0,
                 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    tbl[10] = mk(1, 32'h004000A0, 0, 7'b0000100, 32'h0, 1, 0, 0, 32'h00400200,
                 1, 0, 5'd8, 32'h004000A0, 0, 32'h0, EXC_VECTOR);
    tbl[11] = mk(1, 32'h004000B0, 0, 7'b1100000, 32'h12345678, 0, 0, 0, 32'h0,
                 1, 0, 5'd4, 32'h004000B0, 0, 32'h12345678, EXC_VECTOR);
    tbl[12] = mk(1, 32'h00000000, 1, 7'b0000100, 32'h0, 0, 0, 0, 32'h0,
                 1, 0, 5'd8, 32'hFFFFFFFC, 1, 32'h0, EXC_VECTOR);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_exception", bus.cp0_exception, 0);
    chk("rst_return", bus.cp0_return, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_redir_valid", bus.redir_valid, 0);
    chk("rst_redir_pc", bus.redir_pc, 0);
    chk("rst_busy", bus.busy, 0);
    rstn = 1;
    @(posedge clk); #1;

    // Directed table
    foreach (tbl[i]) run(tbl[i], i % 3);

    // ERET with ack held low 5 cycles; a Sys presented meanwhile must be ignored
    rv = mk(1, 32'h00400300, 0, 7'b0, 32'h0, 1, 0, 0, 32'h00400100,
            0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    drive(rv);
    @(negedge clk);
    chk("eret_return", bus.cp0_return, 1);
    chk("eret_no_exc", bus.cp0_exception, 0);
    @(posedge clk); #1;
    clear_inputs();
    bus.mem_valid = 1; bus.mem_pc = 32'h00400304; bus.mem_exc = 7'b0000100;
    t = 0;
    @(negedge clk);
    while (!bus.redir_valid && t < 40) begin
      chk("nested_flush_ignored", bus.cp0_exception, 0);
      t++;
      @(negedge clk);
    end
    chk("eret_redir_pc", bus.redir_pc, 32'h00400100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ack_low_valid", bus.redir_valid, 1);
      chk("ack_low_pc", bus.redir_pc, 32'h00400100);
      chk("nested_redir_ignored", bus.cp0_exception, 0);
    end
    clear_inputs();
    bus.redir_ack = 1;
    @(posedge clk); #1;
    bus.redir_ack = 0;
    @(negedge clk);
    chk("eret_idle", bus.busy, 0);
    @(posedge clk); #1;

    // Reset while in REDIRECT
    drive(tbl[0]);
    @(posedge clk); #1;
    clear_inputs();
    t = 0;
    @(negedge clk);
    while (!bus.redir_valid && t < 40) begin
      t++;
      @(negedge clk);
    end
    chk("pre_reset_redir", bus.redir_valid, 1);
    rstn = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_redir_valid2", bus.redir_valid, 0);
    chk("rst_redir_pc2", bus.redir_pc, 0);
    chk("rst_busy2", bus.busy, 0);
    chk("rst_flush2", bus.flush, 0);
    rstn = 1;
    @(posedge clk); #1;

`ifdef EXC_STATS_EN
    chk("exc_count_reset", exc_count, 0);
    run(tbl[0], 0);
    run(tbl[6], 0);
    run(tbl[1], 1);
    run(tbl[2], 0);
    chk("exc_count", exc_count, 3);
`endif

    // Randomized against the reference model
    for (int n = 0; n < 80; n++) begin
      rv.valid = ($urandom_range(0, 7) != 0);
      rv.pc    = $urandom;
      rv.bd    = $urandom_range(0, 1);
      rv.exc   = 0;
      for (int b = 0; b < 7; b++) rv.exc[b] = ($urandom_range(0, 5) == 0);
      rv.addr  = $urandom;
      rv.eret  = ($urandom_range(0, 2) == 0);
      rv.intr  = ($urandom_range(0, 3) == 0);
      rv.exl   = $urandom_range(0, 1);
      rv.ra    = $urandom;
      run(model(rv), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
